// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// downstream BCD-to-code stage that consumes its 3-digit operand.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int MAX_BCD_VAL = 999;
  // Operand width agreed with the BCD-to-code transform stage.
  localparam int BCD_OPND_W  = 12;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // 4-bit modular add; legal inputs never exceed 9 so no carry is lost.
  always_comb begin
    q = d;
    if (d >= BCD_DIGIT_W'(5)) q = d + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Operands above MAX_VAL are flagged with OVF instead of being converted.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W   = 10,
  parameter int DIGITS  = 3,
  parameter int MAX_VAL = MAX_BCD_VAL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic [BIN_W-1:0]            BIN_IN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_OUT,
  output logic                        OVF,
  output logic [1:0]                  dbg_state
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  // Handshake: START is accepted on a rising edge whenever the converter is
  // not BUSY (IDLE or FIN); START while BUSY is ignored. DONE is a one-cycle
  // pulse in FIN, after which BCD_OUT/OVF describe the accepted operand.
  // BUSY and DONE are decoded from distinct states and are never both high.

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr, sr_nx, sr_adj, sr_shift;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BCD_W-1:0]  bcd_q, bcd_nx, bcd_adj;
  logic              ovf_q, ovf_nx;
  logic              over;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .d (sr[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
        .q (bcd_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
    end
  endgenerate

  assign sr_adj   = {bcd_adj, sr[BIN_W-1:0]};
  assign sr_shift = sr_adj << 1;
  assign over     = 32'(BIN_IN) > MAX_VAL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      bcd_q <= bcd_nx;
      ovf_q <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    bcd_nx   = bcd_q;
    ovf_nx   = ovf_q;
    case (state)
      IDLE, FIN: begin
        state_nx = IDLE;
        if (START) begin
          sr_nx  = {{BCD_W{1'b0}}, BIN_IN};
          cnt_nx = '0;
          if (over) begin
            // Overflow reports through FIN without touching the held result.
            state_nx = FIN;
            ovf_nx   = 1'b1;
          end else begin
            state_nx = SHIFT;
            ovf_nx   = 1'b0;
          end
        end
      end
      SHIFT: begin
        sr_nx  = sr_shift;
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          bcd_nx   = sr_shift[SR_W-1:BIN_W];
          state_nx = FIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign BUSY      = (state == SHIFT);
  assign DONE      = (state == FIN);
  assign BCD_OUT   = bcd_q;
  assign OVF       = ovf_q;
  assign dbg_state = state;

endmodule
